// File: rtl/weight_read_sequencer_pkg.sv
// Shared weight-path definitions: sequencer states, one-hot kernel-size codes
// and the kernel decoder also used by the BRAM write-count logic.
package weight_read_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L_START,
    ST_L_RUN,
    ST_R_START,
    ST_R_A,
    ST_R_B,
    ST_DONE
  } seq_state_e;

  localparam logic [4:0] KS_1 = 5'b00001;
  localparam logic [4:0] KS_2 = 5'b00010;
  localparam logic [4:0] KS_3 = 5'b00100;
  localparam logic [4:0] KS_4 = 5'b01000;
  localparam logic [4:0] KS_5 = 5'b10000;

  typedef struct packed {
    logic       ok;
    logic [2:0] k;
  } kdec_t;

  // Anything other than exactly one set bit decodes as invalid with K = 0.
  function automatic kdec_t kernel_decode(input logic [4:0] ks);
    kdec_t r;
    r.ok = 1'b1;
    r.k  = 3'd0;
    case (ks)
      KS_1:    r.k = 3'd1;
      KS_2:    r.k = 3'd2;
      KS_3:    r.k = 3'd3;
      KS_4:    r.k = 3'd4;
      KS_5:    r.k = 3'd5;
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/weight_read_sequencer.sv
// Layer-pass scheduler for the BRAM weight controller: runs the preload write
// in a load pass, or streams every (channel, kernel-row) to the MAC array.
module weight_read_sequencer #(
  parameter int BRAM_ADDRESS_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic        cfg_load,
  input  logic [4:0]  cfg_kernel_size,
  input  logic [11:0] cfg_out_ch,
  input  logic        cfg_abort,
  output logic        transfer_start,
  output logic        write_en,
  output logic        port_sel,
  output logic        bram_control_add1,
  output logic        bram_control_add2,
  input  logic        weight_from_bram_valid,
  input  logic        write_weight_finish,
  output logic        wt_valid,
  input  logic        wt_ready,
  output logic [11:0] wt_oc,
  output logic [2:0]  wt_row,
  output logic        wt_last,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
);
  import weight_read_sequencer_pkg::*;

  localparam logic [16:0] MAX_ROWS = 17'd1 << BRAM_ADDRESS_WIDTH;

  seq_state_e  state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [11:0] oc_cfg_q, oc_cfg_d;
  logic [11:0] oc_idx_q, oc_idx_d;
  logic [2:0]  row_q, row_d;
  logic        last_q, last_d;
  logic        cfg_err_q, cfg_err_d;

  kdec_t       cfg_dec;
  logic [14:0] row_total;
  logic        cfg_reject;
  logic        hs;

  assign cfg_dec    = kernel_decode(cfg_kernel_size);
  assign row_total  = 15'(cfg_out_ch) * 15'(cfg_dec.k);
  assign cfg_reject = !cfg_dec.ok || (cfg_out_ch == 12'd0) || ({2'b00, row_total} > MAX_ROWS);
  assign hs         = wt_valid && wt_ready;

  always_comb begin
    state_d           = state_q;
    k_d               = k_q;
    oc_cfg_d          = oc_cfg_q;
    oc_idx_d          = oc_idx_q;
    row_d             = row_q;
    cfg_err_d         = 1'b0;
    bram_control_add2 = 1'b0;
    wt_valid          = ((state_q == ST_R_A) || (state_q == ST_R_B)) && weight_from_bram_valid;

    if (hs) begin
      if (row_q == k_q - 3'd1) begin
        row_d    = 3'd0;
        oc_idx_d = oc_idx_q + 12'd1;
      end else begin
        row_d = row_q + 3'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_reject) begin
            cfg_err_d = 1'b1;
          end else begin
            k_d      = cfg_dec.k;
            oc_cfg_d = cfg_out_ch;
            oc_idx_d = 12'd0;
            row_d    = 3'd0;
            state_d  = cfg_load ? ST_L_START : ST_R_START;
          end
        end
      end
      ST_L_START: state_d = ST_L_RUN;
      ST_L_RUN:   if (write_weight_finish) state_d = ST_DONE;
      ST_R_START: state_d = ST_R_A;
      ST_R_A:     if (hs) state_d = last_q ? ST_DONE : ST_R_B;
      ST_R_B: begin
        if (hs) begin
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            // Both port rows of this address are consumed; move to the next pair.
            bram_control_add2 = 1'b1;
            state_d           = ST_R_A;
          end
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a start or an address advance.
    if (cfg_abort) begin
      state_d           = ST_IDLE;
      bram_control_add2 = 1'b0;
      cfg_err_d         = 1'b0;
    end

    last_d = (oc_idx_d == oc_cfg_d - 12'd1) && (row_d == k_d - 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_q       <= 3'd0;
      oc_cfg_q  <= 12'd0;
      oc_idx_q  <= 12'd0;
      row_q     <= 3'd0;
      last_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      oc_cfg_q  <= oc_cfg_d;
      oc_idx_q  <= oc_idx_d;
      row_q     <= row_d;
      last_q    <= last_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign transfer_start    = (state_q == ST_L_START) || (state_q == ST_R_START);
  assign write_en          = (state_q == ST_L_START) || (state_q == ST_L_RUN);
  assign port_sel          = (state_q == ST_R_B);
  assign done              = (state_q == ST_DONE);
  assign busy              = (state_q != ST_IDLE);
  assign bram_control_add1 = 1'b0;
  assign cfg_err           = cfg_err_q;
  assign wt_oc             = oc_idx_q;
  assign wt_row            = row_q;
  assign wt_last           = last_q;

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Directed bench for weight_read_sequencer with a BRAM-controller stub and a
// row-list model of every handshake a pass must deliver.
module tb_weight_read_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_load = 1'b0;
  logic [4:0]  cfg_kernel_size = 5'd0;
  logic [11:0] cfg_out_ch = 12'd0;
  logic        cfg_abort = 1'b0;
  logic        transfer_start, write_en, port_sel;
  logic        bram_control_add1, bram_control_add2;
  logic        weight_from_bram_valid;
  logic        write_weight_finish = 1'b0;
  logic        wt_valid;
  logic        wt_ready = 1'b0;
  logic [11:0] wt_oc;
  logic [2:0]  wt_row;
  logic        wt_last, busy, done, cfg_err;

  always #5 clk = ~clk;

  weight_read_sequencer #(.BRAM_ADDRESS_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_load(cfg_load),
    .cfg_kernel_size(cfg_kernel_size), .cfg_out_ch(cfg_out_ch),
    .cfg_abort(cfg_abort),
    .transfer_start(transfer_start), .write_en(write_en), .port_sel(port_sel),
    .bram_control_add1(bram_control_add1), .bram_control_add2(bram_control_add2),
    .weight_from_bram_valid(weight_from_bram_valid),
    .write_weight_finish(write_weight_finish),
    .wt_valid(wt_valid), .wt_ready(wt_ready),
    .wt_oc(wt_oc), .wt_row(wt_row), .wt_last(wt_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  // Controller stub: valid rises 3 cycles after a read transfer_start or an add2.
  logic [1:0] rd_cnt;
  always @(posedge clk) begin
    if (rst || cfg_abort) begin
      weight_from_bram_valid <= 1'b0;
      rd_cnt <= 2'd0;
    end else if ((transfer_start && !write_en) || bram_control_add2) begin
      weight_from_bram_valid <= 1'b0;
      rd_cnt <= 2'd2;
    end else if (rd_cnt != 2'd0) begin
      rd_cnt <= rd_cnt - 2'd1;
      if (rd_cnt == 2'd1) weight_from_bram_valid <= 1'b1;
    end
  end

  typedef struct packed {
    logic [11:0] oc;
    logic [2:0]  row;
    logic        last;
    logic        port;
  } row_t;

  row_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   hs_cnt, add2_cnt, done_cnt, err_cnt;
  logic last_port;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Row i of a pass is channel i/K, kernel row i%K, on port i%2.
  task automatic build_model(input int k, input int oc);
    row_t e;
    int n;
    n = k * oc;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      e.oc   = 12'(i / k);
      e.row  = 3'(i % k);
      e.last = (i == n - 1);
      e.port = 1'(i % 2);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("add1_tied", {31'd0, bram_control_add1}, 32'd0);
      if (done) done_cnt++;
      if (cfg_err) err_cnt++;
      if (bram_control_add2) add2_cnt++;
      if (wt_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'd0, wt_valid}, 32'd0);
        end else begin
          check("wt_oc", {20'd0, wt_oc}, {20'd0, exp_q[0].oc});
          check("wt_row", {29'd0, wt_row}, {29'd0, exp_q[0].row});
          check("wt_last", {31'd0, wt_last}, {31'd0, exp_q[0].last});
          check("port_sel", {31'd0, port_sel}, {31'd0, exp_q[0].port});
          check("add2_hs", {31'd0, bram_control_add2},
                {31'd0, wt_ready && exp_q[0].port && !exp_q[0].last && !cfg_abort});
          if (wt_ready) begin
            last_port = port_sel;
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end else begin
        check("add2_idle", {31'd0, bram_control_add2}, 32'd0);
      end
      if (cfg_abort) exp_q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle after the start pulse.
  task automatic start_pass(input logic load, input logic [4:0] ks, input logic [11:0] oc);
    tick();
    cfg_start = 1'b1;
    cfg_load = load;
    cfg_kernel_size = ks;
    cfg_out_ch = oc;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic run_load();
    done_cnt = 0;
    start_pass(1'b1, 5'b00100, 12'd4);
    check("load_ts", {31'd0, transfer_start}, 32'd1);
    check("load_we_first", {31'd0, write_en}, 32'd1);
    for (int w = 2; w <= 12; w++) begin
      tick();
      check("load_we_hold", {31'd0, write_en}, 32'd1);
      check("load_ts_once", {31'd0, transfer_start}, 32'd0);
    end
    write_weight_finish = 1'b1;
    tick();
    write_weight_finish = 1'b0;
    check("load_we_drop", {31'd0, write_en}, 32'd0);
    check("load_done", {31'd0, done}, 32'd1);
    tick();
    check("load_done_clear", {31'd0, done}, 32'd0);
    check("load_busy_end", {31'd0, busy}, 32'd0);
    check("load_done_cnt", done_cnt, 32'd1);
  endtask

  task automatic run_read(input logic [4:0] ks, input int k, input int oc, input bit bp,
                          input int exp_hs, input int exp_add2, input logic exp_last_port);
    int cnt;
    int n;
    n = k * oc;
    build_model(k, oc);
    hs_cnt = 0; add2_cnt = 0; done_cnt = 0; err_cnt = 0;
    wt_ready = !bp;
    start_pass(1'b0, ks, 12'(oc));
    check("rd_ts", {31'd0, transfer_start}, 32'd1);
    check("rd_we", {31'd0, write_en}, 32'd0);
    cnt = 0;
    while (!wt_valid && cnt < 20) begin tick(); cnt++; end
    check("rd_first_latency", cnt, 32'd3);
    if (bp) begin
      for (int r = 0; r < n; r++) begin
        cnt = 0;
        while (!wt_valid && cnt < 20) begin tick(); cnt++; end
        for (int c = 0; c < 7; c++) begin
          check("bp_valid_held", {31'd0, wt_valid}, 32'd1);
          if (r == 0 && c == 2) begin cfg_start = 1'b1; cfg_kernel_size = 5'b00110; end
          if (r == 0 && c == 3) cfg_start = 1'b0;
          tick();
        end
        wt_ready = 1'b1;
        tick();
        wt_ready = 1'b0;
      end
    end
    cnt = 0;
    while (done_cnt == 0 && cnt < 300) begin tick(); cnt++; end
    wt_ready = 1'b0;
    tick(); tick();
    check("rd_busy_end", {31'd0, busy}, 32'd0);
    check("rd_done_cnt", done_cnt, 32'd1);
    check("rd_queue_left", exp_q.size(), 32'd0);
    check("rd_hs_cnt", hs_cnt, exp_hs);
    check("rd_add2_cnt", add2_cnt, exp_add2);
    check("rd_last_port", {31'd0, last_port}, {31'd0, exp_last_port});
    check("rd_no_err_busy", err_cnt, 32'd0);
  endtask

  task automatic try_start(input logic [4:0] ks, input logic [11:0] oc, input logic exp_err);
    start_pass(1'b0, ks, oc);
    check("rej_cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
    check("rej_busy", {31'd0, busy}, {31'd0, !exp_err});
    tick();
    check("rej_cfg_err_clear", {31'd0, cfg_err}, 32'd0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
  endtask

  task automatic abort_load();
    done_cnt = 0;
    start_pass(1'b1, 5'b00100, 12'd4);
    tick(); tick();
    check("ab_l_in_run", {31'd0, write_en}, 32'd1);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("ab_l_we", {31'd0, write_en}, 32'd0);
    check("ab_l_busy", {31'd0, busy}, 32'd0);
    repeat (4) tick();
    check("ab_l_no_done", done_cnt, 32'd0);
  endtask

  task automatic abort_read(input bit with_hs);
    int cnt;
    build_model(2, 3);
    hs_cnt = 0; add2_cnt = 0; done_cnt = 0;
    wt_ready = 1'b1;
    start_pass(1'b0, 5'b00010, 12'd3);
    cnt = 0;
    while (hs_cnt == 0 && cnt < 20) begin tick(); cnt++; end
    wt_ready = with_hs;
    check("ab_r_in_b", {31'd0, port_sel}, 32'd1);
    check("ab_r_valid", {31'd0, wt_valid}, 32'd1);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    wt_ready = 1'b0;
    check("ab_r_busy", {31'd0, busy}, 32'd0);
    check("ab_r_wt_valid", {31'd0, wt_valid}, 32'd0);
    check("ab_r_we", {31'd0, write_en}, 32'd0);
    check("ab_r_ts", {31'd0, transfer_start}, 32'd0);
    repeat (4) tick();
    check("ab_r_no_done", done_cnt, 32'd0);
    check("ab_r_hs_cnt", hs_cnt, with_hs ? 32'd2 : 32'd1);
    check("ab_r_add2_cnt", add2_cnt, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ts", {31'd0, transfer_start}, 32'd0);
    check("rst_we", {31'd0, write_en}, 32'd0);
    check("rst_port", {31'd0, port_sel}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, cfg_err}, 32'd0);
    check("rst_valid", {31'd0, wt_valid}, 32'd0);
    check("rst_oc", {20'd0, wt_oc}, 32'd0);
    check("rst_row", {29'd0, wt_row}, 32'd0);
    check("rst_last", {31'd0, wt_last}, 32'd0);
    rst = 1'b0;
    tick();

    run_load();
    run_read(5'b00010, 2, 3, 1'b0, 6, 2, 1'b1);
    run_read(5'b00001, 1, 3, 1'b0, 3, 1, 1'b0);
    run_read(5'b00010, 2, 2, 1'b1, 4, 1, 1'b1);
    try_start(5'b00110, 12'd3, 1'b1);
    try_start(5'b00100, 12'd0, 1'b1);
    try_start(5'b10000, 12'd1000, 1'b1);
    try_start(5'b00010, 12'd2048, 1'b0);
    try_start(5'b00010, 12'd2049, 1'b1);
    abort_load();
    abort_read(1'b0);
    abort_read(1'b1);
    run_read(5'b00100, 3, 2, 1'b0, 6, 2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
